// File: rtl/cdc_sync_filter_pkg.sv
`default_nettype none
// ============================================================================
// Module  : cdc_sync_filter_pkg
// Brief   : Shared CDC constants and the counter-width helper.
// Revision: 1.0
// ============================================================================
package cdc_sync_filter_pkg;

    localparam int CDC_MIN_STAGES = 2;
    localparam int CDC_MAX_FILTER = 65535;

    // Ceiling log2, never below 1 so a counter always has at least one bit.
    function automatic int cdc_clog2(input int value);
        int width;
        width = 0;
        while ((1 << width) < value) begin
            width = width + 1;
        end
        return (width < 1) ? 1 : width;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cdc_sync_filter_channel.sv
`default_nettype none
// ============================================================================
// Module  : cdc_sync_filter_channel
// Brief   : One-bit synchronizer chain, persistence filter and edge/glitch pulses.
// Revision: 1.0
// ============================================================================
module cdc_sync_filter_channel
    import cdc_sync_filter_pkg::*;
#(
    parameter int   NUM_STAGES    = 2,
    parameter int   FILTER_CYCLES = 4,
    parameter logic INIT_VALUE    = 1'b0
) (
    input  wire logic clk_dst,
    input  wire logic rst_dst_n,
    input  wire logic i_src,
    output logic      o_dst,
    output logic      o_rise,
    output logic      o_fall,
    output logic      o_glitch
);

    (* ASYNC_REG = "TRUE" *) logic [NUM_STAGES-1:0] r_chain;
    logic w_raw;
    logic w_level;
    logic r_dst_q;

    always_ff @(posedge clk_dst) begin
        if (!rst_dst_n) begin
            r_chain <= {NUM_STAGES{INIT_VALUE}};
        end else begin
            r_chain <= {r_chain[NUM_STAGES-2:0], i_src};
        end
    end

    assign w_raw = r_chain[NUM_STAGES-1];

    generate
        if (FILTER_CYCLES == 0) begin : g_bypass
            assign w_level  = w_raw;
            assign o_glitch = 1'b0;
        end else begin : g_filter
            localparam int              CNT_W      = cdc_clog2(FILTER_CYCLES);
            localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(FILTER_CYCLES - 1);

            logic             r_filt;
            logic [CNT_W-1:0] r_cnt;
            logic             r_glitch;

            // A change is accepted only after it persists for FILTER_CYCLES raw samples;
            // returning to the held level mid-count flags an abandoned change.
            always_ff @(posedge clk_dst) begin
                if (!rst_dst_n) begin
                    r_filt   <= INIT_VALUE;
                    r_cnt    <= '0;
                    r_glitch <= 1'b0;
                end else begin
                    r_glitch <= 1'b0;
                    if (w_raw == r_filt) begin
                        r_cnt    <= '0;
                        r_glitch <= (r_cnt != '0);
                    end else if (r_cnt == C_CNT_LAST) begin
                        r_filt <= w_raw;
                        r_cnt  <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
            end

            assign w_level  = r_filt;
            assign o_glitch = r_glitch;
        end
    endgenerate

    // Reset loads the same level as the filter, so release never produces a pulse.
    always_ff @(posedge clk_dst) begin
        if (!rst_dst_n) begin
            r_dst_q <= INIT_VALUE;
        end else begin
            r_dst_q <= w_level;
        end
    end

    assign o_dst  = w_level;
    assign o_rise = w_level & ~r_dst_q;
    assign o_fall = ~w_level & r_dst_q;

endmodule
`default_nettype wire

// File: rtl/cdc_sync_filter.sv
`default_nettype none
// ============================================================================
// Module  : cdc_sync_filter
// Brief   : WIDTH independent synchronized, glitch-filtered inputs with edge pulses.
// Revision: 1.0
// ============================================================================
module cdc_sync_filter
    import cdc_sync_filter_pkg::*;
#(
    parameter int               WIDTH         = 4,
    parameter int               NUM_STAGES    = 2,
    parameter int               FILTER_CYCLES = 4,
    parameter logic [WIDTH-1:0] INIT_VALUE    = '0
) (
    input  wire logic             clk_dst,
    input  wire logic             rst_dst_n,
    input  wire logic [WIDTH-1:0] signal_src,
    output logic      [WIDTH-1:0] signal_dst,
    output logic      [WIDTH-1:0] rise_pulse,
    output logic      [WIDTH-1:0] fall_pulse,
    output logic      [WIDTH-1:0] glitch_pulse,
    output logic                  any_change
);

    generate
        if (NUM_STAGES < CDC_MIN_STAGES) begin : g_err_stages
            $error("cdc_sync_filter: NUM_STAGES must be >= 2");
        end
        if (WIDTH < 1) begin : g_err_width
            $error("cdc_sync_filter: WIDTH must be >= 1");
        end
        if (FILTER_CYCLES > CDC_MAX_FILTER) begin : g_err_filter
            $error("cdc_sync_filter: FILTER_CYCLES must be <= 65535");
        end
    endgenerate

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_chan
            cdc_sync_filter_channel #(
                .NUM_STAGES    (NUM_STAGES),
                .FILTER_CYCLES (FILTER_CYCLES),
                .INIT_VALUE    (INIT_VALUE[gi])
            ) u_chan (
                .clk_dst   (clk_dst),
                .rst_dst_n (rst_dst_n),
                .i_src     (signal_src[gi]),
                .o_dst     (signal_dst[gi]),
                .o_rise    (rise_pulse[gi]),
                .o_fall    (fall_pulse[gi]),
                .o_glitch  (glitch_pulse[gi])
            );
        end
    endgenerate

    assign any_change = |(rise_pulse | fall_pulse);

endmodule
`default_nettype wire

// File: tb/tb_cdc_sync_filter.sv
`default_nettype none
// ============================================================================
// Module  : tb_cdc_sync_filter
// Brief   : Directed checks of synchronizer latency, filtering, pulses and reset.
// Revision: 1.0
// ============================================================================
module tb_cdc_sync_filter;

    logic       clk_dst = 1'b0;
    logic       rst_dst_n;
    logic [3:0] src_a, dst_a, rise_a, fall_a, glitch_a;
    logic       any_a;
    logic [3:0] src_b, dst_b, rise_b, fall_b, glitch_b;
    logic       any_b;

    int checks = 0;
    int errors = 0;

    always #5 clk_dst = ~clk_dst;

    cdc_sync_filter #(
        .WIDTH(4), .NUM_STAGES(2), .FILTER_CYCLES(4), .INIT_VALUE(4'b1010)
    ) dut_a (
        .clk_dst(clk_dst), .rst_dst_n(rst_dst_n), .signal_src(src_a),
        .signal_dst(dst_a), .rise_pulse(rise_a), .fall_pulse(fall_a),
        .glitch_pulse(glitch_a), .any_change(any_a)
    );

    cdc_sync_filter #(
        .WIDTH(4), .NUM_STAGES(3), .FILTER_CYCLES(0), .INIT_VALUE(4'b0000)
    ) dut_b (
        .clk_dst(clk_dst), .rst_dst_n(rst_dst_n), .signal_src(src_b),
        .signal_dst(dst_b), .rise_pulse(rise_b), .fall_pulse(fall_b),
        .glitch_pulse(glitch_b), .any_change(any_b)
    );

    task automatic tick();
        @(posedge clk_dst);
        #1;
    endtask

    task automatic test_reset();
        rst_dst_n = 1'b0;
        src_a = 4'b0000;
        src_b = 4'b0000;
        for (int j = 0; j < 5; j++) begin
            tick();
            checks++;
            if (dst_a !== 4'b1010) begin
                errors++; $display("FAIL reset_dst cyc%0d: got %b want 1010", j, dst_a);
            end
            checks++;
            if ({rise_a, fall_a, glitch_a, any_a} !== 13'd0) begin
                errors++; $display("FAIL reset_pulses cyc%0d: got r%b f%b g%b a%b want 0", j, rise_a, fall_a, glitch_a, any_a);
            end
        end
        checks++;
        if (dst_b !== 4'b0000) begin
            errors++; $display("FAIL reset_dst_b: got %b want 0000", dst_b);
        end
        rst_dst_n = 1'b1;
        for (int j = 0; j < 6; j++) begin
            tick();
            checks++;
            if (dst_a !== ((j < 5) ? 4'b1010 : 4'b0000)) begin
                errors++; $display("FAIL release_dst cyc%0d: got %b", j, dst_a);
            end
            checks++;
            if (fall_a !== ((j == 5) ? 4'b1010 : 4'b0000) || rise_a !== 4'b0000) begin
                errors++; $display("FAIL release_pulses cyc%0d: got f%b r%b", j, fall_a, rise_a);
            end
        end
    endtask

    task automatic test_rise();
        src_a[0] = 1'b1;
        for (int j = 0; j < 7; j++) begin
            tick();
            checks++;
            if (dst_a !== ((j >= 5) ? 4'b0001 : 4'b0000)) begin
                errors++; $display("FAIL rise_dst cyc%0d: got %b", j, dst_a);
            end
            checks++;
            if (rise_a !== ((j == 5) ? 4'b0001 : 4'b0000) || any_a !== (j == 5)) begin
                errors++; $display("FAIL rise_pulse cyc%0d: got r%b a%b", j, rise_a, any_a);
            end
        end
    endtask

    task automatic test_glitch();
        src_a[1] = 1'b1;
        for (int j = 0; j < 8; j++) begin
            tick();
            if (j == 1) src_a[1] = 1'b0;
            checks++;
            if (dst_a !== 4'b0001 || rise_a !== 4'b0000 || fall_a !== 4'b0000) begin
                errors++; $display("FAIL glitch_level cyc%0d: got d%b r%b f%b", j, dst_a, rise_a, fall_a);
            end
            checks++;
            if (glitch_a !== ((j == 4) ? 4'b0010 : 4'b0000)) begin
                errors++; $display("FAIL glitch_pulse cyc%0d: got %b", j, glitch_a);
            end
        end
    endtask

    task automatic test_bypass();
        src_b[2] = 1'b1;
        for (int j = 0; j < 4; j++) begin
            tick();
            checks++;
            if (dst_b !== ((j >= 2) ? 4'b0100 : 4'b0000)) begin
                errors++; $display("FAIL bypass_dst cyc%0d: got %b", j, dst_b);
            end
            checks++;
            if (rise_b !== ((j == 2) ? 4'b0100 : 4'b0000) || glitch_b !== 4'b0000) begin
                errors++; $display("FAIL bypass_pulse cyc%0d: got r%b g%b", j, rise_b, glitch_b);
            end
        end
    endtask

    task automatic test_reset_midcount();
        src_a[2] = 1'b1;
        for (int j = 0; j < 4; j++) begin
            tick();
            checks++;
            if (dst_a !== 4'b0001) begin
                errors++; $display("FAIL midcount_hold cyc%0d: got %b", j, dst_a);
            end
        end
        rst_dst_n = 1'b0;
        for (int j = 0; j < 2; j++) begin
            tick();
            checks++;
            if (dst_a !== 4'b1010 || {rise_a, fall_a, glitch_a, any_a} !== 13'd0) begin
                errors++; $display("FAIL midcount_reset cyc%0d: got d%b r%b f%b g%b", j, dst_a, rise_a, fall_a, glitch_a);
            end
        end
        rst_dst_n = 1'b1;
        for (int j = 0; j < 6; j++) begin
            tick();
            checks++;
            if (dst_a !== ((j < 5) ? 4'b1010 : 4'b0101)) begin
                errors++; $display("FAIL midcount_dst cyc%0d: got %b", j, dst_a);
            end
            checks++;
            if (rise_a !== ((j == 5) ? 4'b0101 : 4'b0000) || fall_a !== ((j == 5) ? 4'b1010 : 4'b0000)) begin
                errors++; $display("FAIL midcount_pulse cyc%0d: got r%b f%b", j, rise_a, fall_a);
            end
        end
    endtask

    task automatic test_simultaneous();
        src_a = 4'b1000;
        repeat (7) tick();
        checks++;
        if (dst_a !== 4'b1000) begin
            errors++; $display("FAIL simul_setup: got %b want 1000", dst_a);
        end
        src_a = 4'b0001;
        for (int j = 0; j < 7; j++) begin
            tick();
            checks++;
            if (dst_a !== ((j >= 5) ? 4'b0001 : 4'b1000)) begin
                errors++; $display("FAIL simul_dst cyc%0d: got %b", j, dst_a);
            end
            checks++;
            if (rise_a !== ((j == 5) ? 4'b0001 : 4'b0000) || fall_a !== ((j == 5) ? 4'b1000 : 4'b0000)
                || any_a !== (j == 5)) begin
                errors++; $display("FAIL simul_pulse cyc%0d: got r%b f%b a%b", j, rise_a, fall_a, any_a);
            end
        end
    endtask

    task automatic test_random();
        logic [3:0] hist[$];
        logic [3:0] prev_dst, prev_rise, prev_fall, prev_glitch, mask;
        int         n;
        bit         ok;
        hist.delete();
        repeat (8) begin
            tick();
            hist.push_back(src_a);
        end
        prev_dst = dst_a; prev_rise = rise_a; prev_fall = fall_a; prev_glitch = glitch_a;
        for (int t = 0; t < 400; t++) begin
            tick();
            hist.push_back(src_a);
            n = hist.size();
            checks++;
            if ((rise_a & prev_rise) != 4'b0 || (fall_a & prev_fall) != 4'b0 || (glitch_a & prev_glitch) != 4'b0) begin
                errors++; $display("FAIL rand_pulse_width t%0d: got r%b f%b g%b", t, rise_a, fall_a, glitch_a);
            end
            checks++;
            if (rise_a !== (dst_a & ~prev_dst) || fall_a !== (~dst_a & prev_dst)) begin
                errors++; $display("FAIL rand_edge t%0d: got r%b f%b want r%b f%b", t, rise_a, fall_a,
                                   dst_a & ~prev_dst, ~dst_a & prev_dst);
            end
            for (int i = 0; i < 4; i++) begin
                if (dst_a[i] !== prev_dst[i]) begin
                    ok = 1'b1;
                    for (int m = 0; m < 4; m++) begin
                        if (hist[n-3-m][i] !== dst_a[i]) ok = 1'b0;
                    end
                    checks++;
                    if (!ok) begin
                        errors++; $display("FAIL rand_persist t%0d bit%0d: got change to %b without 4 stable samples", t, i, dst_a[i]);
                    end
                end
            end
            prev_dst = dst_a; prev_rise = rise_a; prev_fall = fall_a; prev_glitch = glitch_a;
            mask = 4'b0;
            for (int i = 0; i < 4; i++) begin
                mask[i] = ($urandom_range(0, 3) == 0);
            end
            src_a = src_a ^ mask;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_dst_n = 1'b0;
        src_a = 4'b0000;
        src_b = 4'b0000;
        test_reset();
        test_rise();
        test_glitch();
        test_bypass();
        test_reset_midcount();
        test_simultaneous();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
